// File: rtl/pwm_multi.sv
`default_nettype none
// ============================================================================
// Module   : pwm_multi
// Purpose  : Multi-channel PWM generator. All channels share one period
//            counter. The counter runs edge-aligned (0..P, wrap) or
//            center-aligned (0..P..1). Period, duty and mode are
//            double-buffered and move into the active set only on a
//            period boundary, so an output never glitches mid-period.
// Options  : PWM_DEADTIME_EN - adds the dt input, the pwm_n_out output and
//            a per-channel dead-time stage behind the raw compare.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_multi #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
`ifdef PWM_DEADTIME_EN
    ,
    parameter int DT_WIDTH = 4
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [WIDTH-1:0]          period,
    input  logic [CHANNELS*WIDTH-1:0] duty,
    input  logic                      center,
    input  logic                      load,
`ifdef PWM_DEADTIME_EN
    input  logic [DT_WIDTH-1:0]       dt,
    output logic [CHANNELS-1:0]       pwm_n_out,
`endif
    output logic                      load_ack,
    output logic                      period_end,
    output logic [CHANNELS-1:0]       pwm_out
);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

    logic [WIDTH-1:0]    cnt_q, cnt_d;
    dir_t                dir_q, dir_d;
    logic [WIDTH-1:0]    per_act_q, per_act_d, per_sh_q, per_sh_d;
    logic [WIDTH-1:0]    duty_act_q [CHANNELS];
    logic [WIDTH-1:0]    duty_act_d [CHANNELS];
    logic [WIDTH-1:0]    duty_sh_q  [CHANNELS];
    logic [WIDTH-1:0]    duty_sh_d  [CHANNELS];
    logic                mode_act_q, mode_act_d, mode_sh_q, mode_sh_d;
    logic                pending_q, pending_d;
    logic                load_ack_q, load_ack_d;
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic [CHANNELS-1:0] raw_d;
    logic                boundary;
    logic                xfer;

    // Boundary detection on the current (pre-edge) counter state
    always_comb begin
        boundary = 1'b0;
        if (!en) begin
            boundary = 1'b1;
        end else if (!mode_act_q) begin
            boundary = (cnt_q == per_act_q);
        end else begin
            boundary = ((dir_q == DIR_DOWN) && (cnt_q == C_ONE)) || (per_act_q <= C_ONE);
        end
    end

    assign xfer = boundary & pending_q;

    // Shadow capture and shadow->active transfer; a load on the transfer
    // cycle lands in shadow and keeps pending set for the next boundary
    always_comb begin
        per_act_d  = per_act_q;
        mode_act_d = mode_act_q;
        duty_act_d = duty_act_q;
        per_sh_d   = per_sh_q;
        mode_sh_d  = mode_sh_q;
        duty_sh_d  = duty_sh_q;
        pending_d  = pending_q;
        load_ack_d = 1'b0;
        if (xfer) begin
            per_act_d  = per_sh_q;
            mode_act_d = mode_sh_q;
            duty_act_d = duty_sh_q;
            pending_d  = 1'b0;
            load_ack_d = 1'b1;
        end
        if (load) begin
            per_sh_d  = period;
            mode_sh_d = center;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_sh_d[i] = duty[i*WIDTH +: WIDTH];
            end
            pending_d = 1'b1;
        end
    end

    // Period counter; a transfer restarts the period so a mode change
    // always begins at cnt=0 counting up
    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (!en || xfer) begin
            cnt_d = '0;
            dir_d = DIR_UP;
        end else if (!mode_act_q) begin
            cnt_d = (cnt_q >= per_act_q) ? '0 : cnt_q + 1'b1;
        end else if (dir_q == DIR_UP) begin
            if (cnt_q >= per_act_q) begin
                if (per_act_q <= C_ONE) begin
                    // P of 0 or 1: no room to descend, bounce straight to 0
                    cnt_d = '0;
                    dir_d = DIR_UP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    dir_d = DIR_DOWN;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            if (cnt_q <= C_ONE) begin
                cnt_d = '0;
                dir_d = DIR_UP;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Raw compare against the next counter value and next active duty, so
    // the output moves on the same edge as the counter
    always_comb begin
        raw_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            raw_d[i] = en && (cnt_d < duty_act_d[i]);
        end
    end

`ifdef PWM_DEADTIME_EN
    logic [DT_WIDTH:0]   stab_q [CHANNELS];
    logic [DT_WIDTH:0]   stab_d [CHANNELS];
    logic [CHANNELS-1:0] raw_q;
    logic [CHANNELS-1:0] pwm_n_q, pwm_n_d;

    // Dead time: count how long the raw level has held; a side turns on
    // only once the level has been stable for more than dt cycles
    always_comb begin
        pwm_d   = '0;
        pwm_n_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (raw_d[i] != raw_q[i]) begin
                stab_d[i] = (DT_WIDTH+1)'(1);
            end else if (stab_q[i] != '1) begin
                stab_d[i] = stab_q[i] + 1'b1;
            end else begin
                stab_d[i] = stab_q[i];
            end
            pwm_d[i]   = raw_d[i] && (stab_d[i] > {1'b0, dt});
            pwm_n_d[i] = en && !raw_d[i] && (stab_d[i] > {1'b0, dt});
        end
    end

    // Dead-time state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            raw_q   <= '0;
            pwm_n_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                stab_q[i] <= '0;
            end
        end else begin
            raw_q   <= raw_d;
            pwm_n_q <= pwm_n_d;
            stab_q  <= stab_d;
        end
    end

    assign pwm_n_out = pwm_n_q;
`else
    assign pwm_d = raw_d;
`endif

    // Main state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            dir_q      <= DIR_UP;
            per_act_q  <= '1;
            per_sh_q   <= '1;
            mode_act_q <= 1'b0;
            mode_sh_q  <= 1'b0;
            pending_q  <= 1'b0;
            load_ack_q <= 1'b0;
            pwm_q      <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_act_q[i] <= '0;
                duty_sh_q[i]  <= '0;
            end
        end else begin
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            per_act_q  <= per_act_d;
            per_sh_q   <= per_sh_d;
            mode_act_q <= mode_act_d;
            mode_sh_q  <= mode_sh_d;
            pending_q  <= pending_d;
            load_ack_q <= load_ack_d;
            pwm_q      <= pwm_d;
            duty_act_q <= duty_act_d;
            duty_sh_q  <= duty_sh_d;
        end
    end

    assign load_ack   = load_ack_q;
    assign period_end = en & boundary;
    assign pwm_out    = pwm_q;

endmodule
`default_nettype wire
